// File: rtl/ahb_bus_arbiter.sv
// ============================================================================
// ahb_bus_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that lets NUM_MASTERS AHB masters share one AHB-Lite
// slave path (slave, address decoder, HREADY mux).  The arbiter follows the
// transfer stream of the current address-phase owner so that ownership only
// changes on legal boundaries: never inside a fixed-length burst, never
// inside an open-length (INCR) burst while its owner still requests, and
// never inside a locked sequence.
//
// Ports
//   i_hclk       in   1            bus clock, everything on the rising edge
//   i_hreset     in   1            synchronous reset, active-high
//   i_hbusreq    in   NUM_MASTERS  bus request, one bit per master
//   i_hlock      in   NUM_MASTERS  locked-transfer request, one bit per master
//   i_htrans     in   2            HTRANS of the current address-phase owner
//   i_hburst     in   3            HBURST of the current address-phase owner
//   i_hready     in   1            bus-wide ready from the slave HREADY mux
//   o_hgrant     out  NUM_MASTERS  one-hot grant (registered)
//   o_hmaster    out  MW           address-phase owner index (registered)
//   o_hmastlock  out  1            current address phase is locked (registered)
//
// Parameters
//   NUM_MASTERS  number of requesting masters (2..8)
//   MW           width of o_hmaster, clog2(NUM_MASTERS)
//   DEF_MASTER   master parked on the bus when nobody requests
// ============================================================================
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS),
    parameter int DEF_MASTER  = 0
) (
    input  logic                   i_hclk,
    input  logic                   i_hreset,
    input  logic [NUM_MASTERS-1:0] i_hbusreq,
    input  logic [NUM_MASTERS-1:0] i_hlock,
    input  logic [1:0]             i_htrans,
    input  logic [2:0]             i_hburst,
    input  logic                   i_hready,
    output logic [NUM_MASTERS-1:0] o_hgrant,
    output logic [MW-1:0]          o_hmaster,
    output logic                   o_hmastlock
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_ARB    = 2'd0;
    localparam logic [1:0] ST_BURST  = 2'd1;
    localparam logic [1:0] ST_INCR   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR = 3'b001;

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEF_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEF_MASTER;
    localparam logic [MW:0]            NM_WIDE   = (MW+1)'(NUM_MASTERS);

    // Beats remaining after the NONSEQ beat, for each HBURST encoding.
    // SINGLE and INCR both load zero; INCR length is tracked by the FSM.
    function automatic logic [4:0] burstLenM1(input logic [2:0] burst);
        case (burst)
            3'b000, 3'b001: return 5'd0;
            3'b010, 3'b011: return 5'd3;
            3'b100, 3'b101: return 5'd7;
            default:        return 5'd15;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] r_grant;
    logic [MW-1:0]          r_grantIdx;
    logic [MW-1:0]          r_hmaster;
    logic                   r_hmastlock;
    logic [MW-1:0]          r_rrPtr;
    logic [4:0]             r_beatCnt;
    logic [1:0]             r_state;

    logic                   w_isNonseq;
    logic                   w_isSeq;
    logic                   w_isIdle;
    logic                   w_ownerLock;
    logic                   w_ownerReq;
    logic [4:0]             w_loadCnt;
    logic [1:0]             w_startState;
    logic [1:0]             w_nextState;
    logic [4:0]             w_nextCnt;
    logic                   w_handoverDone;
    logic                   w_arbOk;
    logic                   w_anyReq;
    logic [MW-1:0]          w_winner;
    logic [NUM_MASTERS-1:0] w_winnerOneHot;
    logic [MW:0]            w_scanIdx;
    logic                   w_found;

    // ------------------------------------------------------------------------
    // Decode of the owner's current address phase.  HTRANS/HBURST arrive
    // muxed by o_hmaster, so the owner's HLOCK and HBUSREQ are looked up with
    // the same index to stay consistent with the transfer being observed.
    // ------------------------------------------------------------------------
    always_comb begin
        w_isNonseq  = (i_htrans == HTRANS_NONSEQ);
        w_isSeq     = (i_htrans == HTRANS_SEQ);
        w_isIdle    = (i_htrans == HTRANS_IDLE);
        w_ownerLock = i_hlock[r_hmaster];
        w_ownerReq  = i_hbusreq[r_hmaster];
        w_loadCnt   = burstLenM1(i_hburst);
    end

    // ------------------------------------------------------------------------
    // State that a freshly accepted NONSEQ leads to.  A held HLOCK dominates
    // the burst type: the whole sequence must stay on one master, whatever
    // its burst shape, until the owner releases the lock with an IDLE.
    // ------------------------------------------------------------------------
    always_comb begin
        w_startState = ST_ARB;
        if (w_ownerLock) begin
            w_startState = ST_LOCKED;
        end else if (i_hburst == HBURST_INCR) begin
            w_startState = ST_INCR;
        end else if (w_loadCnt != 5'd0) begin
            w_startState = ST_BURST;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and beat counter.  Nothing advances while HREADY is low, so
    // a wait-stated beat is never counted twice and never ends a burst early.
    // The counter reloads on every accepted NONSEQ and counts accepted SEQ
    // beats down, saturating at zero (open-length and locked sequences may
    // run past zero).  BUSY is never a beat.  An IDLE that cuts a fixed burst
    // short also clears the counter so ARB always sees a clean count.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_beatCnt;
        if (i_hready) begin
            if (w_isNonseq) begin
                w_nextCnt = w_loadCnt;
            end else if (w_isSeq && (r_beatCnt != 5'd0)) begin
                w_nextCnt = r_beatCnt - 5'd1;
            end

            case (r_state)
                ST_ARB: begin
                    if (w_isNonseq) begin
                        w_nextState = w_startState;
                    end
                end
                ST_BURST: begin
                    if (w_isSeq) begin
                        if (r_beatCnt <= 5'd1) begin
                            w_nextState = ST_ARB;
                        end
                    end else if (w_isNonseq) begin
                        w_nextState = w_startState;
                    end else if (w_isIdle) begin
                        w_nextState = ST_ARB;
                        w_nextCnt   = 5'd0;
                    end
                end
                ST_INCR: begin
                    if (w_isIdle || w_isNonseq || !w_ownerReq) begin
                        w_nextState = ST_ARB;
                    end
                end
                default: begin
                    if (w_isIdle && !w_ownerLock) begin
                        w_nextState = ST_ARB;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration window.  Regrant only when the transfer stream is at a
    // boundary (next state ARB) and the previously granted master has
    // actually reached the address phase; otherwise a new grantee would lose
    // the bus before it could issue its first NONSEQ.
    // ------------------------------------------------------------------------
    always_comb begin
        w_handoverDone = (r_hmaster == r_grantIdx);
        w_arbOk        = i_hready && (w_nextState == ST_ARB) && w_handoverDone;
        w_anyReq       = |i_hbusreq;
    end

    // ------------------------------------------------------------------------
    // Round-robin search starting just after the last winner.  The last
    // winner is visited last, so it keeps the bus only when it is the sole
    // requester.  With no requests at all the bus parks on DEF_MASTER.
    // ------------------------------------------------------------------------
    always_comb begin
        w_winner  = DEF_IDX;
        w_found   = 1'b0;
        w_scanIdx = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_scanIdx = {1'b0, r_rrPtr} + (MW+1)'(i);
            if (w_scanIdx >= NM_WIDE) begin
                w_scanIdx = w_scanIdx - NM_WIDE;
            end
            if (!w_found && i_hbusreq[w_scanIdx[MW-1:0]]) begin
                w_winner = w_scanIdx[MW-1:0];
                w_found  = 1'b1;
            end
        end
        w_winnerOneHot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_winner;
    end

    // ------------------------------------------------------------------------
    // Registered outputs and bookkeeping.  Reset drops any burst in flight
    // on the spot and parks the bus.  The address-phase owner follows the
    // grant one accepted cycle later, and HMASTLOCK travels with it.  The
    // pointer only moves for a real requester, so parking on DEF_MASTER does
    // not disturb the rotation.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_grant     <= DEF_GRANT;
            r_grantIdx  <= DEF_IDX;
            r_hmaster   <= DEF_IDX;
            r_hmastlock <= 1'b0;
            r_rrPtr     <= DEF_IDX;
            r_beatCnt   <= 5'd0;
            r_state     <= ST_ARB;
        end else if (i_hready) begin
            r_state     <= w_nextState;
            r_beatCnt   <= w_nextCnt;
            r_hmaster   <= r_grantIdx;
            r_hmastlock <= i_hlock[r_grantIdx];
            if (w_arbOk) begin
                r_grant    <= w_winnerOneHot;
                r_grantIdx <= w_winner;
                if (w_anyReq) begin
                    r_rrPtr <= w_winner;
                end
            end
        end
    end

    assign o_hgrant    = r_grant;
    assign o_hmaster   = r_hmaster;
    assign o_hmastlock = r_hmastlock;

    // ------------------------------------------------------------------------
    // The grant vector and its index are kept side by side; they must always
    // agree and the grant must never be empty or shared.
    // ------------------------------------------------------------------------
    a_grantOneHot : assert property (@(posedge i_hclk) disable iff (i_hreset)
        $onehot(r_grant));

    a_grantIdxMatch : assert property (@(posedge i_hclk) disable iff (i_hreset)
        r_grant == ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_grantIdx));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ============================================================================
// tb_ahb_bus_arbiter
// ----------------------------------------------------------------------------
// Directed bench for ahb_bus_arbiter with four masters.  Inputs change on the
// falling edge; every stimulus step spans one rising edge and outputs are
// examined at the following falling edge.
// ============================================================================
module tb_ahb_bus_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;
    localparam logic [2:0] WRAP16 = 3'b110;

    localparam logic [3:0] NONE = 4'b0000;

    logic       hclk;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int checkCount;
    int failCount;

    int expGrantIdx[9]  = '{1, 1, 2, 2, 3, 3, 0, 0, 1};
    int expMasterIdx[9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};

    ahb_bus_arbiter #(
        .NUM_MASTERS (4),
        .MW          (2),
        .DEF_MASTER  (0)
    ) dut (
        .i_hclk      (hclk),
        .i_hreset    (hreset),
        .i_hbusreq   (hbusreq),
        .i_hlock     (hlock),
        .i_htrans    (htrans),
        .i_hburst    (hburst),
        .i_hready    (hready),
        .o_hgrant    (hgrant),
        .o_hmaster   (hmaster),
        .o_hmastlock (hmastlock)
    );

    // Free-running bus clock, 10 ns period.
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Drive one cycle of inputs, then wait for the falling edge after the
    // rising edge that consumes them.
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input logic ready);
        hbusreq = req;
        hlock   = lock;
        htrans  = trans;
        hburst  = burst;
        hready  = ready;
        @(negedge hclk);
    endtask

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        hreset = 1'b1;
        applyStimulus(NONE, NONE, IDLE, SINGLE, 1'b1);
        applyStimulus(NONE, NONE, IDLE, SINGLE, 1'b1);
        hreset = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        hreset  = 1'b1;
        hbusreq = NONE;
        hlock   = NONE;
        htrans  = IDLE;
        hburst  = SINGLE;
        hready  = 1'b1;

        // ---------------- reset state and parking ----------------
        $display("[TB] reset and park");
        resetDut();
        checkOutput("rst_grant",    32'(hgrant),          32'h1);
        checkOutput("rst_hmaster",  32'(hmaster),         32'h0);
        checkOutput("rst_mastlock", 32'(hmastlock),       32'h0);
        checkOutput("rst_state",    32'(dut.r_state),     32'h0);
        checkOutput("rst_beatcnt",  32'(dut.r_beatCnt),   32'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(NONE, NONE, IDLE, SINGLE, 1'b1);
            checkOutput("park_grant", 32'(hgrant), 32'h1);
        end
        checkOutput("park_hmaster", 32'(hmaster), 32'h0);

        // ---------------- M1 INCR4 while M2 waits ----------------
        $display("[TB] INCR4 on M1 with M2 waiting");
        applyStimulus(4'b0110, NONE, IDLE, SINGLE, 1'b1);
        checkOutput("i4_grant_m1",   32'(hgrant),  32'h2);
        checkOutput("i4_hmaster_m0", 32'(hmaster), 32'h0);
        applyStimulus(4'b0110, NONE, IDLE, SINGLE, 1'b1);
        checkOutput("i4_hold_handover", 32'(hgrant),  32'h2);
        checkOutput("i4_hmaster_m1",    32'(hmaster), 32'h1);
        applyStimulus(4'b0110, NONE, NONSEQ, INCR4, 1'b1);
        checkOutput("i4_b1_grant", 32'(hgrant),        32'h2);
        checkOutput("i4_b1_state", 32'(dut.r_state),   32'h1);
        checkOutput("i4_b1_cnt",   32'(dut.r_beatCnt), 32'h3);
        applyStimulus(4'b0110, NONE, SEQ, INCR4, 1'b1);
        checkOutput("i4_b2_grant", 32'(hgrant),        32'h2);
        checkOutput("i4_b2_cnt",   32'(dut.r_beatCnt), 32'h2);
        applyStimulus(4'b0110, NONE, SEQ, INCR4, 1'b1);
        checkOutput("i4_b3_grant", 32'(hgrant),        32'h2);
        applyStimulus(4'b0110, NONE, SEQ, INCR4, 1'b1);
        checkOutput("i4_b4_grant",   32'(hgrant),        32'h4);
        checkOutput("i4_b4_hmaster", 32'(hmaster),       32'h1);
        checkOutput("i4_b4_state",   32'(dut.r_state),   32'h0);
        checkOutput("i4_b4_cnt",     32'(dut.r_beatCnt), 32'h0);
        applyStimulus(4'b0100, NONE, IDLE, SINGLE, 1'b1);
        checkOutput("i4_hmaster_m2", 32'(hmaster), 32'h2);
        checkOutput("i4_grant_m2",   32'(hgrant),  32'h4);

        // ---------------- all request, SINGLE transfers ----------------
        $display("[TB] round-robin rotation");
        resetDut();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b1111, NONE, NONSEQ, SINGLE, 1'b1);
            checkOutput("rr_grant",   32'(hgrant),  32'(4'b0001 << expGrantIdx[i]));
            checkOutput("rr_hmaster", 32'(hmaster), 32'(expMasterIdx[i]));
        end

        // ---------------- M3 INCR8 with wait states ----------------
        $display("[TB] INCR8 with wait states");
        resetDut();
        applyStimulus(4'b1000, NONE, IDLE, SINGLE, 1'b1);
        checkOutput("i8_grant_m3", 32'(hgrant), 32'h8);
        applyStimulus(4'b1000, NONE, IDLE, SINGLE, 1'b1);
        checkOutput("i8_hmaster_m3", 32'(hmaster), 32'h3);
        applyStimulus(4'b1000, NONE, NONSEQ, INCR8, 1'b1);
        checkOutput("i8_b1_cnt", 32'(dut.r_beatCnt), 32'h7);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b1001, NONE, SEQ, INCR8, 1'b1);
            checkOutput("i8_grant_held", 32'(hgrant), 32'h8);
        end
        checkOutput("i8_b5_cnt", 32'(dut.r_beatCnt), 32'h3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1001, NONE, SEQ, INCR8, 1'b0);
            checkOutput("i8_wait_grant", 32'(hgrant),        32'h8);
            checkOutput("i8_wait_cnt",   32'(dut.r_beatCnt), 32'h3);
            checkOutput("i8_wait_state", 32'(dut.r_state),   32'h1);
        end
        applyStimulus(4'b1001, NONE, SEQ, INCR8, 1'b1);
        checkOutput("i8_b6_cnt", 32'(dut.r_beatCnt), 32'h2);
        applyStimulus(4'b1001, NONE, SEQ, INCR8, 1'b1);
        checkOutput("i8_b7_grant", 32'(hgrant), 32'h8);
        applyStimulus(4'b1001, NONE, SEQ, INCR8, 1'b1);
        checkOutput("i8_b8_grant",   32'(hgrant),  32'h1);
        checkOutput("i8_b8_hmaster", 32'(hmaster), 32'h3);
        applyStimulus(4'b0001, NONE, IDLE, SINGLE, 1'b1);
        checkOutput("i8_hmaster_m0", 32'(hmaster), 32'h0);

        // ---------------- locked INCR on M2, M0 waiting ----------------
        $display("[TB] locked sequence");
        resetDut();
        applyStimulus(4'b0100, 4'b0100, IDLE, SINGLE, 1'b1);
        checkOutput("lk_grant_m2",    32'(hgrant),    32'h4);
        checkOutput("lk_mastlock_m0", 32'(hmastlock), 32'h0);
        applyStimulus(4'b0100, 4'b0100, IDLE, SINGLE, 1'b1);
        checkOutput("lk_hmaster_m2", 32'(hmaster),   32'h2);
        checkOutput("lk_mastlock",   32'(hmastlock), 32'h1);
        applyStimulus(4'b0101, 4'b0100, NONSEQ, INCR, 1'b1);
        checkOutput("lk_state",      32'(dut.r_state), 32'h3);
        checkOutput("lk_grant_held", 32'(hgrant),      32'h4);
        applyStimulus(4'b0101, 4'b0100, SEQ, INCR, 1'b1);
        checkOutput("lk_seq_grant", 32'(hgrant), 32'h4);
        applyStimulus(4'b0101, 4'b0100, IDLE, INCR, 1'b1);
        checkOutput("lk_idle_locked_grant", 32'(hgrant),      32'h4);
        checkOutput("lk_idle_locked_state", 32'(dut.r_state), 32'h3);
        applyStimulus(4'b0101, NONE, IDLE, INCR, 1'b1);
        checkOutput("lk_release_grant", 32'(hgrant),    32'h1);
        checkOutput("lk_release_lock",  32'(hmastlock), 32'h0);
        applyStimulus(4'b0001, NONE, IDLE, SINGLE, 1'b1);
        checkOutput("lk_hmaster_m0", 32'(hmaster), 32'h0);

        // ---------------- unlocked INCR ended by dropping HBUSREQ ----------------
        $display("[TB] open-length burst release");
        resetDut();
        applyStimulus(4'b0010, NONE, IDLE, SINGLE, 1'b1);
        applyStimulus(4'b0010, NONE, IDLE, SINGLE, 1'b1);
        applyStimulus(4'b0011, NONE, NONSEQ, INCR, 1'b1);
        checkOutput("inc_state", 32'(dut.r_state), 32'h2);
        applyStimulus(4'b0011, NONE, SEQ, INCR, 1'b1);
        checkOutput("inc_grant_held", 32'(hgrant), 32'h2);
        applyStimulus(4'b0001, NONE, SEQ, INCR, 1'b1);
        checkOutput("inc_release_grant", 32'(hgrant),      32'h1);
        checkOutput("inc_release_state", 32'(dut.r_state), 32'h0);

        // ---------------- reset in the middle of a WRAP16 ----------------
        $display("[TB] reset mid WRAP16");
        resetDut();
        applyStimulus(4'b0010, NONE, IDLE, SINGLE, 1'b1);
        applyStimulus(4'b0010, NONE, IDLE, SINGLE, 1'b1);
        applyStimulus(4'b0010, NONE, NONSEQ, WRAP16, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, NONE, SEQ, WRAP16, 1'b1);
        end
        checkOutput("w16_b6_cnt",   32'(dut.r_beatCnt), 32'd10);
        checkOutput("w16_b6_grant", 32'(hgrant),        32'h2);
        hreset = 1'b1;
        applyStimulus(4'b0010, NONE, SEQ, WRAP16, 1'b1);
        hreset = 1'b0;
        checkOutput("w16_rst_grant",   32'(hgrant),        32'h1);
        checkOutput("w16_rst_state",   32'(dut.r_state),   32'h0);
        checkOutput("w16_rst_cnt",     32'(dut.r_beatCnt), 32'h0);
        checkOutput("w16_rst_hmaster", 32'(hmaster),       32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
